// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the logic_unit ALUOp/flag interface.
// Accepts a decoded opcode/funct on start, drives ALUOp for the issue, shift
// and sample cycles, then reports result_we/branch_taken/ovf_exception with
// a one-cycle done pulse.
// Optional feature: define ALU_SEQ_ILLEGAL_EN to flag unlisted encodings via
// the illegal output. When it is undefined, those encodings run as PASS_A.
module alu_op_sequencer #(
    parameter int unsigned SHIFT_CYCLES = 2,
    parameter bit          OVF_TRAP     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ZERO,
    input  logic       OVERFLOW,
    input  logic       Update_UC,
    output logic [3:0] ALUOp,
    output logic       busy,
    output logic       done,
    output logic       result_we,
    output logic       branch_taken,
    output logic       ovf_exception,
    output logic       illegal
);

    localparam logic [3:0] OP_PASS_A = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_SLT    = 4'h4;
    localparam logic [3:0] OP_SLL    = 4'h5;
    localparam logic [3:0] OP_SRL    = 4'h6;
    localparam logic [3:0] OP_SRA    = 4'h7;
    localparam logic [3:0] OP_SLLV   = 4'h8;
    localparam logic [3:0] OP_SRAV   = 4'h9;
    localparam logic [3:0] OP_BEQ    = 4'hA;
    localparam logic [3:0] OP_BNE    = 4'hB;
    localparam logic [3:0] OP_BLE    = 4'hC;
    localparam logic [3:0] OP_BGT    = 4'hD;

    // SHIFT state lasts SHIFT_CYCLES-1 cycles; counter runs 0 .. SHIFT_CYCLES-2.
    localparam int unsigned      CNT_W    = (SHIFT_CYCLES > 2) ? $clog2(SHIFT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SHIFT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             checked_q;
    logic             ill_q;

    logic [3:0] dec_code;
    logic       dec_checked;
    logic       dec_valid;
    logic       is_shift;
    logic       is_branch;
    logic       ovf_now;

    // ZERO is part of the logic_unit interface; the branch decision arrives
    // already resolved on Update_UC, so ZERO is not needed here.
    logic unused_inputs;
`ifdef ALU_SEQ_ILLEGAL_EN
    assign unused_inputs = ZERO;
`else
    assign unused_inputs = ZERO ^ dec_valid;
`endif

    // Decode opcode/funct into an ALUOp code, overflow-check flag and validity
    always_comb begin
        dec_code    = OP_PASS_A;
        dec_checked = 1'b0;
        dec_valid   = 1'b1;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20: begin dec_code = OP_ADD; dec_checked = 1'b1; end
                6'h21: dec_code = OP_ADD;
                6'h22: begin dec_code = OP_SUB; dec_checked = 1'b1; end
                6'h23: dec_code = OP_SUB;
                6'h24: dec_code = OP_AND;
                6'h2A: dec_code = OP_SLT;
                6'h00: dec_code = OP_SLL;
                6'h02: dec_code = OP_SRL;
                6'h03: dec_code = OP_SRA;
                6'h04: dec_code = OP_SLLV;
                6'h07: dec_code = OP_SRAV;
                default: dec_valid = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'h08: begin dec_code = OP_ADD; dec_checked = 1'b1; end
                6'h09: dec_code = OP_ADD;
                6'h0C: dec_code = OP_AND;
                6'h0A: dec_code = OP_SLT;
                6'h04: dec_code = OP_BEQ;
                6'h05: dec_code = OP_BNE;
                6'h06: dec_code = OP_BLE;
                6'h07: dec_code = OP_BGT;
                6'h20, 6'h21, 6'h23,
                6'h28, 6'h29, 6'h2B: dec_code = OP_ADD;
                default: dec_valid = 1'b0;
            endcase
        end
    end

    // Classify the operation currently held on ALUOp
    always_comb begin
        is_shift  = (ALUOp >= OP_SLL) && (ALUOp <= OP_SRAV);
        is_branch = (ALUOp >= OP_BEQ) && (ALUOp <= OP_BGT);
        ovf_now   = OVF_TRAP && checked_q && OVERFLOW && !ill_q;
    end

    // Sequencer FSM with registered ALUOp, status and result outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            checked_q     <= 1'b0;
            ill_q         <= 1'b0;
            ALUOp         <= OP_PASS_A;
            busy          <= 1'b0;
            done          <= 1'b0;
            result_we     <= 1'b0;
            branch_taken  <= 1'b0;
            ovf_exception <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            done          <= 1'b0;
            result_we     <= 1'b0;
            branch_taken  <= 1'b0;
            ovf_exception <= 1'b0;
            illegal       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_ISSUE;
                        busy      <= 1'b1;
                        checked_q <= dec_checked;
                        ALUOp     <= dec_code;
`ifdef ALU_SEQ_ILLEGAL_EN
                        ill_q     <= !dec_valid;
`else
                        ill_q     <= 1'b0;
`endif
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                    if (is_shift && (SHIFT_CYCLES > 1)) begin
                        state <= S_SHIFT;
                    end else begin
                        state <= S_SAMPLE;
                    end
                end
                S_SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    state         <= S_DONE;
                    done          <= 1'b1;
                    ALUOp         <= OP_PASS_A;
                    ovf_exception <= ovf_now;
                    branch_taken  <= is_branch && Update_UC && !ill_q;
                    result_we     <= !is_branch && !ovf_now && !ill_q;
                    illegal       <= ill_q;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    ALUOp <= OP_PASS_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: the driver checks ALUOp/busy per
// cycle, and a scoreboard checks the result flags and done timing.
module tb_alu_op_sequencer;

    localparam int unsigned SC = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       ZERO;
    logic       OVERFLOW;
    logic       Update_UC;
    logic [3:0] ALUOp;
    logic       busy;
    logic       done;
    logic       result_we;
    logic       branch_taken;
    logic       ovf_exception;
    logic       illegal;

    alu_op_sequencer #(
        .SHIFT_CYCLES(SC),
        .OVF_TRAP(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .opcode(opcode),
        .funct(funct),
        .ZERO(ZERO),
        .OVERFLOW(OVERFLOW),
        .Update_UC(Update_UC),
        .ALUOp(ALUOp),
        .busy(busy),
        .done(done),
        .result_we(result_we),
        .branch_taken(branch_taken),
        .ovf_exception(ovf_exception),
        .illegal(illegal)
    );

    typedef struct {
        logic we;
        logic bt;
        logic ovf;
        logic ill;
        int   done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference decode table written from the instruction list
    function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                  output logic [3:0] code, output logic chk, output logic valid);
        code  = 4'h0;
        chk   = 1'b0;
        valid = 1'b1;
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin code = 4'h1; chk = 1'b1; end
                6'h21: code = 4'h1;
                6'h22: begin code = 4'h2; chk = 1'b1; end
                6'h23: code = 4'h2;
                6'h24: code = 4'h3;
                6'h2A: code = 4'h4;
                6'h00: code = 4'h5;
                6'h02: code = 4'h6;
                6'h03: code = 4'h7;
                6'h04: code = 4'h8;
                6'h07: code = 4'h9;
                default: valid = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin code = 4'h1; chk = 1'b1; end
                6'h09: code = 4'h1;
                6'h0C: code = 4'h3;
                6'h0A: code = 4'h4;
                6'h04: code = 4'hA;
                6'h05: code = 4'hB;
                6'h06: code = 4'hC;
                6'h07: code = 4'hD;
                6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: code = 4'h1;
                default: valid = 1'b0;
            endcase
        end
    endfunction

    // Scoreboard: pop one expectation per done pulse; flags must be 0 otherwise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check_eq("result_we", 32'(result_we), 32'(e.we));
                    check_eq("branch_taken", 32'(branch_taken), 32'(e.bt));
                    check_eq("ovf_exception", 32'(ovf_exception), 32'(e.ovf));
                    check_eq("illegal", 32'(illegal), 32'(e.ill));
                end
            end else begin
                check_eq("flags_outside_done",
                         32'({result_we, branch_taken, ovf_exception, illegal}), 32'd0);
            end
        end
    end

    // One operation: flags are driven inverted except in the SAMPLE cycle
    task automatic do_op(input logic [5:0] op, input logic [5:0] fn,
                         input logic ovf_in, input logic uuc_in);
        logic [3:0] code;
        logic       chk;
        logic       valid;
        logic       ill;
        logic       br;
        exp_t       e;
        int         lat;
        model(op, fn, code, chk, valid);
`ifdef ALU_SEQ_ILLEGAL_EN
        ill = !valid;
`else
        ill = 1'b0;
`endif
        if (ill) code = 4'h0;
        br  = (code >= 4'hA);
        lat = (code >= 4'h5 && code <= 4'h9) ? 2 + int'(SC) : 3;
        @(negedge clk);
        opcode    = op;
        funct     = fn;
        start     = 1'b1;
        OVERFLOW  = !ovf_in;
        Update_UC = !uuc_in;
        e.ovf = chk && ovf_in && !ill;
        e.bt  = br && uuc_in && !ill;
        e.ill = ill;
        e.we  = !br && !e.ovf && !ill;
        e.done_cyc = cyc + lat;
        sb.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start  = 1'b0;
            opcode = 6'($urandom);
            funct  = 6'($urandom);
            check_eq("busy_active", 32'(busy), 32'd1);
            if (k < lat) begin
                check_eq("aluop_hold", 32'(ALUOp), 32'(code));
            end else begin
                check_eq("aluop_done_zero", 32'(ALUOp), 32'd0);
            end
            OVERFLOW  = (k == lat - 1) ? ovf_in : !ovf_in;
            Update_UC = (k == lat - 1) ? uuc_in : !uuc_in;
        end
        @(negedge clk);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("aluop_idle", 32'(ALUOp), 32'd0);
    endtask

    localparam int N_LEGAL = 22;
    logic [11:0] legal [N_LEGAL] = '{
        {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23},
        {6'h00, 6'h24}, {6'h00, 6'h2A}, {6'h00, 6'h00}, {6'h00, 6'h02},
        {6'h00, 6'h03}, {6'h00, 6'h04}, {6'h00, 6'h07}, {6'h08, 6'h00},
        {6'h09, 6'h00}, {6'h0C, 6'h00}, {6'h0A, 6'h00}, {6'h04, 6'h00},
        {6'h05, 6'h00}, {6'h06, 6'h00}, {6'h07, 6'h00}, {6'h23, 6'h00},
        {6'h2B, 6'h00}, {6'h20, 6'h00}
    };

    initial begin
        int c;
        logic [11:0] pick;
        reset     = 1'b0;
        start     = 1'b0;
        opcode    = '0;
        funct     = '0;
        ZERO      = 1'b0;
        OVERFLOW  = 1'b0;
        Update_UC = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_aluop", 32'(ALUOp), 32'd0);
        reset = 1'b1;

        // Checked vs unchecked arithmetic with overflow present
        do_op(6'h00, 6'h20, 1'b1, 1'b0);
        do_op(6'h00, 6'h21, 1'b1, 1'b0);
        do_op(6'h00, 6'h22, 1'b1, 1'b0);
        do_op(6'h00, 6'h23, 1'b1, 1'b0);
        do_op(6'h08, 6'h00, 1'b1, 1'b0);
        do_op(6'h09, 6'h00, 1'b1, 1'b0);
        do_op(6'h23, 6'h00, 1'b1, 1'b0);
        do_op(6'h00, 6'h20, 1'b0, 1'b0);
        // Shifts
        do_op(6'h00, 6'h03, 1'b0, 1'b0);
        do_op(6'h00, 6'h00, 1'b0, 1'b1);
        do_op(6'h00, 6'h07, 1'b1, 1'b0);
        // Branches
        do_op(6'h04, 6'h00, 1'b0, 1'b1);
        do_op(6'h04, 6'h00, 1'b0, 1'b0);
        do_op(6'h05, 6'h00, 1'b1, 1'b1);
        do_op(6'h07, 6'h00, 1'b0, 1'b1);
        // Unlisted encodings
        do_op(6'h3F, 6'h00, 1'b1, 1'b1);
        do_op(6'h00, 6'h3F, 1'b0, 1'b0);

        // Random legal operations
        for (int i = 0; i < 24; i++) begin
            pick = legal[$urandom_range(N_LEGAL - 1)];
            do_op(pick[11:6], pick[5:0], 1'($urandom), 1'($urandom));
        end

        // start held high: next op accepted only in the cycle after DONE
        @(negedge clk);
        c = cyc;
        opcode    = 6'h00;
        funct     = 6'h21;
        OVERFLOW  = 1'b0;
        Update_UC = 1'b0;
        start     = 1'b1;
        sb.push_back('{we: 1'b1, bt: 1'b0, ovf: 1'b0, ill: 1'b0, done_cyc: c + 3});
        sb.push_back('{we: 1'b1, bt: 1'b0, ovf: 1'b0, ill: 1'b0, done_cyc: c + 7});
        repeat (4) @(negedge clk);
        check_eq("b2b_idle_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("b2b_second_issue", 32'(ALUOp), 32'd1);
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("b2b_end_busy", 32'(busy), 32'd0);

        // Reset in the middle of a shift aborts without a done pulse
        @(negedge clk);
        opcode = 6'h00;
        funct  = 6'h03;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("midreset_shift_aluop", 32'(ALUOp), 32'd7);
        reset = 1'b0;
        @(negedge clk);
        check_eq("midreset_busy", 32'(busy), 32'd0);
        check_eq("midreset_aluop", 32'(ALUOp), 32'd0);
        check_eq("midreset_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("midreset_stays_idle", 32'(busy), 32'd0);

        // A final op after the abort must still work normally
        do_op(6'h00, 6'h24, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
